// File: rtl/npc_lsu_pkg.sv
// npc_lsu_pkg: shared types and constants for the load/store unit.
// FSM state enum, access size encodings, byte-lane mask constants and
// the alignment predicate used when NPC_LSU_MISALIGN_CHECK_EN is defined.
package npc_lsu_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2,
    StResp = 2'd3
  } lsu_state_e;

  // Access size encodings; 2'd3 is handled as a word.
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // Byte-lane masks before shifting into place.
  localparam logic [3:0] MASK_NONE = 4'b0000;
  localparam logic [3:0] MASK_B    = 4'b0001;
  localparam logic [3:0] MASK_H    = 4'b0011;
  localparam logic [3:0] MASK_W    = 4'b1111;

  // A half must be 2-byte aligned, a word (or size 3) 4-byte aligned.
  function automatic logic f_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic w_mis;
    w_mis = 1'b0;
    if (size == SZ_H) begin
      w_mis = addr_lo[0];
    end else if (size != SZ_B) begin
      w_mis = (addr_lo != 2'b00);
    end
    return w_mis;
  endfunction

endpackage

// File: rtl/npc_lsu_align.sv
// npc_lsu_align: combinational byte-lane placement for stores and
// shift/extension for loads. Offsets below the access size are ignored so
// halves use addr[1] only and words use no offset bits.
module npc_lsu_align
  import npc_lsu_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  input  logic        i_unsigned,
  output logic [3:0]  o_wmask,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [1:0]  w_off;
  logic [31:0] w_shifted;

  // Decode the effective lane offset and the store lane placement.
  always_comb begin
    w_off   = 2'b00;
    o_wmask = MASK_W;
    o_wdata = i_wdata;
    case (i_size)
      SZ_B: begin
        w_off   = i_addr_lo;
        o_wmask = MASK_B << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
      end
      SZ_H: begin
        w_off   = {i_addr_lo[1], 1'b0};
        o_wmask = MASK_H << {i_addr_lo[1], 1'b0};
        o_wdata = {2{i_wdata[15:0]}};
      end
      default: begin
        w_off   = 2'b00;
        o_wmask = MASK_W;
        o_wdata = i_wdata;
      end
    endcase
  end

  assign w_shifted = i_rdata >> {w_off, 3'b000};

  // Extract the addressed byte/half and sign- or zero-extend it.
  always_comb begin
    o_rdata = i_rdata;
    case (i_size)
      SZ_B: o_rdata = i_unsigned ? {24'h0, w_shifted[7:0]}
                                 : {{24{w_shifted[7]}}, w_shifted[7:0]};
      SZ_H: o_rdata = i_unsigned ? {16'h0, w_shifted[15:0]}
                                 : {{16{w_shifted[15]}}, w_shifted[15:0]};
      default: o_rdata = i_rdata;
    endcase
  end

endmodule

// File: rtl/npc_lsu.sv
// npc_lsu: multi-cycle load/store unit bridging the execute stage to a
// valid/ready memory bus. One transaction in flight: IDLE -> REQ -> WAIT -> RESP.
// Optional feature: define NPC_LSU_MISALIGN_CHECK_EN to reject misaligned
// half/word accesses with resp_err instead of silently aligning them.
module npc_lsu
  import npc_lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_wen,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_unsigned,
  output logic              o_resp_valid,
  input  logic              i_resp_ready,
  output logic [DATA_W-1:0] o_resp_rdata,
  output logic              o_resp_err,
  output logic              o_mem_req_valid,
  input  logic              i_mem_req_ready,
  output logic              o_mem_wen,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic [3:0]        o_mem_wmask,
  input  logic              i_mem_resp_valid,
  output logic              o_mem_resp_ready,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  lsu_state_e        r_state;
  logic              r_wen;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;

  logic [3:0]        w_wmask;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_rdata_ext;
  logic              w_reject;

  npc_lsu_align u_align (
    .i_size     (r_size),
    .i_addr_lo  (r_addr[1:0]),
    .i_wdata    (r_wdata),
    .i_rdata    (i_mem_rdata),
    .i_unsigned (r_unsigned),
    .o_wmask    (w_wmask),
    .o_wdata    (w_wdata),
    .o_rdata    (w_rdata_ext)
  );

`ifdef NPC_LSU_MISALIGN_CHECK_EN
  assign w_reject   = f_misaligned(i_req_size, i_req_addr[1:0]);
  assign o_resp_err = r_err;
`else
  assign w_reject   = 1'b0;
  assign o_resp_err = 1'b0;
`endif

  // FSM, request latches and response register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= StIdle;
      r_wen      <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_size     <= SZ_B;
      r_unsigned <= 1'b0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (i_req_valid) begin
            r_wen      <= i_req_wen;
            r_addr     <= i_req_addr;
            r_wdata    <= i_req_wdata;
            r_size     <= i_req_size;
            r_unsigned <= i_req_unsigned;
            r_rdata    <= '0;
            r_err      <= w_reject;
            r_state    <= w_reject ? StResp : StReq;
          end
        end
        StReq: begin
          if (i_mem_req_ready) r_state <= StWait;
        end
        StWait: begin
          if (i_mem_resp_valid) begin
            r_rdata <= r_wen ? '0 : w_rdata_ext;
            r_state <= StResp;
          end
        end
        StResp: begin
          if (i_resp_ready) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_req_ready      = (r_state == StIdle);
  assign o_mem_req_valid  = (r_state == StReq);
  assign o_mem_resp_ready = (r_state == StWait);
  assign o_resp_valid     = (r_state == StResp);
  assign o_resp_rdata     = r_rdata;
  assign o_mem_wen        = r_wen;
  assign o_mem_addr       = {r_addr[ADDR_W-1:2], 2'b00};
  // Loads present an empty mask and zero data on the bus.
  assign o_mem_wmask      = r_wen ? w_wmask : MASK_NONE;
  assign o_mem_wdata      = r_wen ? w_wdata : '0;

endmodule

// File: tb/tb_npc_lsu.sv
// tb_npc_lsu: directed bench for npc_lsu. Inputs change on the falling edge,
// outputs are sampled on the falling edge before inputs are updated.
module tb_npc_lsu;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid;
  logic        mem_resp_ready;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_errors = 0;
  int n_bus_req = 0;
  int n_resp = 0;

  npc_lsu dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .i_req_valid      (req_valid),
    .o_req_ready      (req_ready),
    .i_req_wen        (req_wen),
    .i_req_addr       (req_addr),
    .i_req_wdata      (req_wdata),
    .i_req_size       (req_size),
    .i_req_unsigned   (req_unsigned),
    .o_resp_valid     (resp_valid),
    .i_resp_ready     (resp_ready),
    .o_resp_rdata     (resp_rdata),
    .o_resp_err       (resp_err),
    .o_mem_req_valid  (mem_req_valid),
    .i_mem_req_ready  (mem_req_ready),
    .o_mem_wen        (mem_wen),
    .o_mem_addr       (mem_addr),
    .o_mem_wdata      (mem_wdata),
    .o_mem_wmask      (mem_wmask),
    .i_mem_resp_valid (mem_resp_valid),
    .o_mem_resp_ready (mem_resp_ready),
    .i_mem_rdata      (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake counters on both the bus request and the core response.
  always @(posedge clk) begin
    if (!reset && mem_req_valid && mem_req_ready) n_bus_req <= n_bus_req + 1;
    if (!reset && resp_valid && resp_ready) n_resp <= n_resp + 1;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h want=%h", tag, act, exp);
    end
  endtask

  task automatic drive_req(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [1:0] size, input logic uns);
    req_valid    = 1'b1;
    req_wen      = wen;
    req_addr     = addr;
    req_wdata    = wdata;
    req_size     = size;
    req_unsigned = uns;
  endtask

  // Best-case access: bus always ready, response immediately available.
  task automatic do_access(input string tag, input logic wen, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                           input logic [31:0] mrd, input logic [31:0] e_addr,
                           input logic [31:0] e_wdata, input logic [3:0] e_mask,
                           input logic [31:0] e_rdata);
    @(negedge clk);
    chk({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    drive_req(wen, addr, wdata, size, uns);
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b1;
    mem_rdata      = mrd;
    resp_ready     = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    chk({tag, ".mem_req_valid"}, 32'(mem_req_valid), 32'd1);
    chk({tag, ".mem_wen"}, 32'(mem_wen), 32'(wen));
    chk({tag, ".mem_addr"}, mem_addr, e_addr);
    chk({tag, ".mem_wdata"}, mem_wdata, e_wdata);
    chk({tag, ".mem_wmask"}, 32'(mem_wmask), 32'(e_mask));
    @(negedge clk);
    chk({tag, ".mem_resp_ready"}, 32'(mem_resp_ready), 32'd1);
    @(negedge clk);
    chk({tag, ".resp_valid"}, 32'(resp_valid), 32'd1);
    chk({tag, ".resp_rdata"}, resp_rdata, e_rdata);
    chk({tag, ".resp_err"}, 32'(resp_err), 32'd0);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready     = 1'b0;
    mem_resp_valid = 1'b0;
    mem_req_ready  = 1'b0;
    chk({tag, ".idle"}, 32'(req_ready), 32'd1);
  endtask

  int base_req;
  int base_resp;

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0;
    req_size = 2'd0; req_unsigned = 1'b0; resp_ready = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset values.
    chk("rst.req_ready", 32'(req_ready), 32'd1);
    chk("rst.resp_valid", 32'(resp_valid), 32'd0);
    chk("rst.mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst.mem_resp_ready", 32'(mem_resp_ready), 32'd0);
    chk("rst.resp_err", 32'(resp_err), 32'd0);
    chk("rst.mem_wen", 32'(mem_wen), 32'd0);
    chk("rst.resp_rdata", resp_rdata, 32'd0);
    chk("rst.mem_addr", mem_addr, 32'd0);
    chk("rst.mem_wdata", mem_wdata, 32'd0);
    chk("rst.mem_wmask", 32'(mem_wmask), 32'd0);

    // Directed accesses.
    do_access("sb3", 1'b1, 32'h8000_0003, 32'h0000_00A5, 2'd0, 1'b0, 32'hDEAD_BEEF,
              32'h8000_0000, 32'hA5A5_A5A5, 4'b1000, 32'h0);
    do_access("lb2", 1'b0, 32'h8000_0002, 32'h0, 2'd0, 1'b0, 32'h12F0_3456,
              32'h8000_0000, 32'h0, 4'b0000, 32'hFFFF_FFF0);
    do_access("lbu2", 1'b0, 32'h8000_0002, 32'h0, 2'd0, 1'b1, 32'h12F0_3456,
              32'h8000_0000, 32'h0, 4'b0000, 32'h0000_00F0);
    do_access("lb1pos", 1'b0, 32'h8000_0001, 32'h0, 2'd0, 1'b0, 32'hFF00_7F00,
              32'h8000_0000, 32'h0, 4'b0000, 32'h0000_007F);
    do_access("lh2", 1'b0, 32'h8000_0002, 32'h0, 2'd1, 1'b0, 32'h8001_0000,
              32'h8000_0000, 32'h0, 4'b0000, 32'hFFFF_8001);
    do_access("lhu0", 1'b0, 32'h8000_0000, 32'h0, 2'd1, 1'b1, 32'hFFFF_9ABC,
              32'h8000_0000, 32'h0, 4'b0000, 32'h0000_9ABC);
    do_access("lw4", 1'b0, 32'h8000_0004, 32'h0, 2'd2, 1'b0, 32'hCAFE_BABE,
              32'h8000_0004, 32'h0, 4'b0000, 32'hCAFE_BABE);
    do_access("sh2", 1'b1, 32'h8000_0002, 32'h1234_BEEF, 2'd1, 1'b0, 32'h5555_5555,
              32'h8000_0000, 32'hBEEF_BEEF, 4'b1100, 32'h0);
    do_access("sb1", 1'b1, 32'h8000_0021, 32'hFFFF_FF3C, 2'd0, 1'b0, 32'h0,
              32'h8000_0020, 32'h3C3C_3C3C, 4'b0010, 32'h0);
    do_access("sz3st", 1'b1, 32'h8000_000C, 32'h1122_3344, 2'd3, 1'b0, 32'h0,
              32'h8000_000C, 32'h1122_3344, 4'b1111, 32'h0);

    // Backpressure on every handshake; a competing request stays asserted.
    base_req  = n_bus_req;
    base_resp = n_resp;
    @(negedge clk);
    drive_req(1'b0, 32'h8000_0006, 32'h0, 2'd1, 1'b1);
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 32'hFEDC_0000;
    @(negedge clk);
    drive_req(1'b1, 32'h9000_0000, 32'h7777_7777, 2'd2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("bp.req_valid_hold", 32'(mem_req_valid), 32'd1);
      chk("bp.addr_hold", mem_addr, 32'h8000_0004);
      chk("bp.wmask_hold", 32'(mem_wmask), 32'd0);
      chk("bp.req_ready_low", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("bp.wait_hold", 32'(mem_resp_ready), 32'd1);
      chk("bp.no_resp", 32'(resp_valid), 32'd0);
      @(negedge clk);
    end
    mem_resp_valid = 1'b1;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    mem_rdata = 32'h1111_1111;
    for (int i = 0; i < 2; i++) begin
      chk("bp.resp_hold", 32'(resp_valid), 32'd1);
      chk("bp.rdata_hold", resp_rdata, 32'h0000_FEDC);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    req_valid  = 1'b0;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("bp.back_idle", 32'(req_ready), 32'd1);
    chk("bp.bus_reqs", 32'(n_bus_req - base_req), 32'd1);
    chk("bp.resps", 32'(n_resp - base_resp), 32'd1);

    // Misaligned word load.
    base_req = n_bus_req;
    @(negedge clk);
    drive_req(1'b0, 32'h8000_0001, 32'h0, 2'd2, 1'b0);
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 32'h0BAD_F00D;
`ifdef NPC_LSU_MISALIGN_CHECK_EN
    @(negedge clk);
    req_valid = 1'b0;
    chk("mis.resp_valid", 32'(resp_valid), 32'd1);
    chk("mis.resp_err", 32'(resp_err), 32'd1);
    chk("mis.resp_rdata", resp_rdata, 32'd0);
    chk("mis.no_mem_req", 32'(mem_req_valid), 32'd0);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("mis.bus_reqs", 32'(n_bus_req - base_req), 32'd0);
`else
    @(negedge clk);
    req_valid = 1'b0;
    chk("mis.mem_req_valid", 32'(mem_req_valid), 32'd1);
    chk("mis.mem_addr", mem_addr, 32'h8000_0000);
    @(negedge clk);
    @(negedge clk);
    chk("mis.resp_valid", 32'(resp_valid), 32'd1);
    chk("mis.resp_err", 32'(resp_err), 32'd0);
    chk("mis.resp_rdata", resp_rdata, 32'h0BAD_F00D);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("mis.bus_reqs", 32'(n_bus_req - base_req), 32'd1);
`endif
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;

    // Reset while waiting for the bus response.
    @(negedge clk);
    drive_req(1'b0, 32'h8000_0008, 32'h0, 2'd2, 1'b0);
    mem_req_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("rstw.in_wait", 32'(mem_resp_ready), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rstw.req_ready", 32'(req_ready), 32'd1);
    chk("rstw.resp_valid", 32'(resp_valid), 32'd0);
    chk("rstw.mem_resp_ready", 32'(mem_resp_ready), 32'd0);
    chk("rstw.mem_req_valid", 32'(mem_req_valid), 32'd0);
    do_access("sw10", 1'b1, 32'h8000_0010, 32'h89AB_CDEF, 2'd2, 1'b0, 32'h0,
              32'h8000_0010, 32'h89AB_CDEF, 4'b1111, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/npc_lsu.md
# npc_lsu

Multi-cycle load/store unit sitting directly downstream of the core's decode/ALU stage: it takes an effective address, store data and access size from the execute path, and replaces the core's direct memory-port calls with a valid/ready memory bus transaction. It handles byte/half/word sizing, byte-lane placement, write masks and load sign/zero extension. Results return to the register writeback mux through a response handshake.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; fixed at 32 (four byte lanes)
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  core presents a load/store
- req_ready  out  1  LSU can accept; high only in IDLE
- req_wen  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  effective byte address (src1 + imm)
- req_wdata  in  DATA_W  store data, right-aligned (rs2)
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = treated as word
- req_unsigned  in  1  zero-extend load (lbu/lhu)
- resp_valid  out  1  access complete
- resp_ready  in  1  core accepts response
- resp_rdata  out  DATA_W  extended load data; 0 for stores
- resp_err  out  1  misaligned access (see Configuration)
- mem_req_valid  out  1  bus request valid
- mem_req_ready  in  1  bus accepts request
- mem_wen  out  1  bus write
- mem_addr  out  ADDR_W  word-aligned address {addr[31:2], 2'b00}
- mem_wdata  out  DATA_W  lane-placed store data
- mem_wmask  out  4  byte-lane write mask
- mem_resp_valid  in  1  bus read data / write ack valid
- mem_resp_ready  out  1  high only in WAIT
- mem_rdata  in  DATA_W  bus read word

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: req_ready = 1. On req_valid: latch wen, addr, wdata, size, unsigned. Next state is REQ, or RESP with err when the misalign check fires.
- REQ: mem_req_valid = 1, with mem_* driven from the latched fields and held stable until mem_req_ready. On handshake, go to WAIT.
- WAIT: mem_resp_ready = 1. On mem_resp_valid:
  - Load: latch the extended data into resp_rdata.
  - Store: latch 0 into resp_rdata.
  - Go to RESP.
- RESP: resp_valid = 1, with resp_rdata and resp_err held until resp_ready. On resp_ready, go to IDLE.
- Store lane placement:
  - Byte: mem_wdata = {4{wdata[7:0]}}, mask = 4'b0001 << addr[1:0].
  - Half: mem_wdata = {2{wdata[15:0]}}, mask = 4'b0011 << {addr[1], 1'b0}.
  - Word: mem_wdata = wdata, mask = 4'b1111.
- Load extraction:
  - Shift mem_rdata right by 8*addr[1:0] (byte) or 16*addr[1] (half).
  - Sign-extend from bit 7 or bit 15, or zero-extend when unsigned.
  - Word loads pass mem_rdata through.
- Loads drive mem_wmask = 4'b0000 and mem_wdata = 0.

## Timing
- Reset: state = IDLE. req_ready = 1; resp_valid, mem_req_valid, mem_resp_ready, resp_err and mem_wen = 0; resp_rdata, mem_addr, mem_wdata and mem_wmask = 0.
- Best-case latency: accept at cycle N; REQ at N+1 with mem_req_ready same cycle; WAIT at N+2 with mem_resp_valid same cycle; resp_valid at N+3.
- A misaligned reject with the check enabled gives resp_valid at N+1, with no bus activity.
- Backpressure on either bus side or on resp_ready stalls in the current state with all outputs stable.
- Only one outstanding transaction. req_valid outside IDLE is ignored, since req_ready = 0.
- Reset mid-transaction forces IDLE next cycle and drops the transaction. The memory shares the same reset, so no stale response arrives.
- mem_resp_valid in any state other than WAIT is ignored.

## Configuration
- NPC_LSU_MISALIGN_CHECK_EN defined:
  - Misaligned means a half with addr[0] = 1, or a word with addr[1:0] != 0.
  - A misaligned request goes IDLE -> RESP with resp_err = 1 and resp_rdata = 0, and never asserts mem_req_valid.
- Undefined:
  - Low address bits beyond the size alignment are cleared: half ignores addr[0], word ignores addr[1:0].
  - resp_err is tied to 0.

## Structure
- Package npc_lsu_pkg holds the state enum (IDLE/REQ/WAIT/RESP), the size encodings (SZ_B = 0, SZ_H = 1, SZ_W = 2) and the 4-bit mask constants.
- Sub-module npc_lsu_align is purely combinational: size, addr[1:0], wdata, rdata and unsigned in; wmask, lane-placed wdata and extended rdata out.
- npc_lsu holds the FSM, request latches and response register.

## Test plan
- sb, addr 0x80000003, wdata 0x000000A5 -> mem_addr 0x80000000, mem_wmask 4'b1000, mem_wdata 0xA5A5A5A5, resp_rdata 0.
- lb, addr 0x80000002, mem_rdata 0x12F0_3456, signed -> resp_rdata 0xFFFFFFF0. Same access with req_unsigned = 1 -> 0x000000F0.
- lh, addr 0x80000002, mem_rdata 0x8001_0000 -> resp_rdata 0xFFFF8001. lw, addr 0x80000004 -> mem_rdata passed unchanged.
- Backpressure: mem_req_ready low 3 cycles, mem_resp_valid delayed 2 cycles, resp_ready low 2 cycles -> outputs stable throughout, exactly one bus request, one response.
- With NPC_LSU_MISALIGN_CHECK_EN: lw at 0x80000001 -> resp_err = 1 one cycle after accept, mem_req_valid never high. Without the macro: same request -> mem_addr 0x80000000, resp_err = 0.
- reset asserted in WAIT -> next cycle IDLE, req_ready = 1, resp_valid = 0. A new sw to 0x80000010 then completes normally with mask 4'b1111.
